coreabc_init_loader: RTL



---
 rtl/coreabc_init_pkg.sv | 6 +
 rtl/coreabc_init_timeout.sv | 16 +
 rtl/coreabc_init_loader.sv | 89 ++++++++
 3 files changed

// File: rtl/coreabc_init_pkg.sv
// coreabc_init_pkg: loader FSM state enum and stream-format constants shared by coreabc_init_loader and its bench
package coreabc_init_pkg;
  typedef enum logic [2:0] {HDR_LO, HDR_HI, CHECK, DAT_LO, DAT_HI, WRITE, CSUM, DONE} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 2;
endpackage

// File: rtl/coreabc_init_timeout.sv
// coreabc_init_timeout: idle watchdog; clk/rst, i_clr restarts, i_en counts idle cycles, o_expired pulses on the TIMEOUT-th idle cycle (TIMEOUT=0 disables)
module coreabc_init_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr || !i_en) ? '0 : r_cnt + W'(1);
  assign o_expired = TIMEOUT != 0 && i_en && !i_clr && r_cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/coreabc_init_loader.sv
// coreabc_init_loader: byte-stream to 9-bit CoreABC RAM init loader; CLK/RST, SRC_VALID/SRC_DATA/SRC_READY in, INITADDR/INITDATA/INITDATVAL/INITDONE/INITERR/WORDCNT out; INIT_CHKSUM_EN adds a trailing XOR checksum byte
module coreabc_init_loader
  import coreabc_init_pkg::*;
#(
  parameter int INITWIDTH = 7,
  parameter int MAXWORDS  = 128,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SRC_VALID,
  input  logic [7:0]           SRC_DATA,
  output logic                 SRC_READY,
  output logic [INITWIDTH-1:0] INITADDR,
  output logic [8:0]           INITDATA,
  output logic                 INITDATVAL,
  output logic                 INITDONE,
  output logic                 INITERR,
  output logic [15:0]          WORDCNT
);
  state_t r_state, w_next_base, w_next;
  logic [15:0] r_count, r_wordcnt;
  logic [INITWIDTH-1:0] r_addr;
  logic [8:0] r_data;
  logic r_err, w_accept, w_clr, w_expired, w_csum_bad, w_err_set;
`ifdef INIT_CHKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] r_xor;
  always_ff @(posedge CLK)
    r_xor <= RST ? '0 : w_accept ? r_xor ^ SRC_DATA : r_xor;
  assign w_csum_bad = r_state == CSUM && w_accept && (r_xor ^ SRC_DATA) != '0;
`else
  localparam state_t TAIL = DONE;
  assign w_csum_bad = 1'b0;
`endif
  assign w_accept = SRC_VALID && SRC_READY;
  assign w_clr = w_accept || w_next_base != r_state;
  assign w_next = w_expired ? DONE : w_next_base;
  assign w_err_set = w_expired || w_csum_bad || (r_state == CHECK && r_count > 16'(MAXWORDS));
  coreabc_init_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(CLK),
    .rst(RST),
    .i_clr(w_clr),
    .i_en(SRC_READY),
    .o_expired(w_expired)
  );
  always_ff @(posedge CLK)
    r_state <= RST ? HDR_LO : w_next;
  always_comb begin
    w_next_base = r_state;
    case (r_state)
      HDR_LO:  w_next_base = w_accept ? HDR_HI : HDR_LO;
      HDR_HI:  w_next_base = w_accept ? CHECK : HDR_HI;
      CHECK:   w_next_base = r_count == '0 ? TAIL : r_count > 16'(MAXWORDS) ? DONE : DAT_LO;
      DAT_LO:  w_next_base = w_accept ? DAT_HI : DAT_LO;
      DAT_HI:  w_next_base = w_accept ? WRITE : DAT_HI;
      WRITE:   w_next_base = r_wordcnt + 16'd1 == r_count ? TAIL : DAT_LO;
      CSUM:    w_next_base = w_accept ? DONE : CSUM;
      default: w_next_base = DONE;
    endcase
  end
  always_comb begin
    SRC_READY = !RST && r_state inside {HDR_LO, HDR_HI, DAT_LO, DAT_HI, CSUM};
    INITDATVAL = r_state == WRITE;
    INITDONE = r_state == DONE;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      r_count <= '0;
      r_wordcnt <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= r_err || w_err_set;
      if (w_accept && r_state == HDR_LO) r_count[7:0] <= SRC_DATA;
      if (w_accept && r_state == HDR_HI) r_count[15:8] <= SRC_DATA;
      if (w_accept && r_state == DAT_LO) r_data[7:0] <= SRC_DATA;
      if (w_accept && r_state == DAT_HI) r_data[8] <= SRC_DATA[0];
      if (r_state == WRITE) begin
        r_addr <= r_addr + INITWIDTH'(1);
        r_wordcnt <= r_wordcnt + 16'd1;
      end
    end
  assign INITADDR = r_addr;
  assign INITDATA = r_data;
  assign INITERR = r_err;
  assign WORDCNT = r_wordcnt;
endmodule
